// File: rtl/serial_mem_pkg.sv
// rtl/serial_mem_pkg.sv - shared states and opcodes for the serial memory responder
package serial_mem_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        WAIT = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam logic [1:0] OP_READ       = 2'd1;
    localparam logic [1:0] OP_WRITE      = 2'd2;
    localparam logic [1:0] OP_BYTE_WRITE = 2'd3;
    localparam int         WORD_BITS     = 16;

endpackage

// File: rtl/serial_mem_ram.sv
// rtl/serial_mem_ram.sv - synchronous word RAM, byte-enabled write port, write-first read port
module serial_mem_ram
    import serial_mem_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [1:0]           be_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [WORD_BITS-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [AW-1:0]        raddr_i,
    output logic [WORD_BITS-1:0] rdata_o
);

    logic [WORD_BITS-1:0] mem_q [0:(1<<AW)-1];
    logic [WORD_BITS-1:0] rdata_q;
    logic [WORD_BITS-1:0] merged_d;

    // Merge enabled bytes of the incoming word with the stored word
    always_comb begin
        merged_d = mem_q[waddr_i];
        if (be_i[0]) merged_d[7:0]  = wdata_i[7:0];
        if (be_i[1]) merged_d[15:8] = wdata_i[15:8];
    end

    // Storage write and registered read; a same-address write is forwarded
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= merged_d;
        if (re_i) rdata_q <= (we_i && (waddr_i == raddr_i)) ? merged_d : mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/serial_mem_responder.sv
// rtl/serial_mem_responder.sv - serial memory bus responder; byte write enabled by SERIAL_MEM_BYTE_WRITE_EN
module serial_mem_responder
    import serial_mem_pkg::*;
#(
    parameter int IO_BITS        = 2,
    parameter int MEM_WORDS_LOG2 = 8,
    parameter int RESP_DELAY     = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tx_fetch,
    input  logic                      tx_jump,
    input  logic [IO_BITS-1:0]        tx_pins,
    output logic [IO_BITS-1:0]        rx_pins,
    output logic                      busy,
    input  logic                      ld_we,
    input  logic [MEM_WORDS_LOG2-1:0] ld_addr,
    input  logic [15:0]               ld_data
);

    localparam int AW    = MEM_WORDS_LOG2;
    localparam int BEATS = WORD_BITS / IO_BITS;

    state_t             state_q;
    logic [4:0]         beat_q;
    logic [3:0]         wait_q;
    logic [1:0]         op_q;
    logic               jump_q;
    logic [15:0]        addr_q;
    logic [15:0]        data_q;
    logic [15:0]        pc_q;
    logic [15:0]        shift_q;
    logic [IO_BITS-1:0] rx_q;

    logic [1:0]         cmd_op;
    logic               cmd_ok;
    logic               is_byte;
    logic               fetch_start;
    logic               last_beat;
    logic               commit;
    logic [15:0]        addr_d;
    logic [15:0]        data_d;
    state_t             resp_state_d;
    logic [IO_BITS-1:0] resp_rx_d;

    logic               ram_we;
    logic [1:0]         ram_be;
    logic [AW-1:0]      ram_waddr;
    logic [15:0]        ram_wdata;
    logic               ram_re;
    logic [AW-1:0]      ram_raddr;
    logic [15:0]        ram_rdata;

    // High address bits alias and bit 0 only matters for byte writes
    logic               unused_bits;
    assign unused_bits = ^{addr_q, addr_d, pc_q};

    generate
        if (IO_BITS == 1) begin : g_op1
            assign cmd_op = {1'b0, tx_pins[0]};
        end else begin : g_opn
            assign cmd_op = tx_pins[1:0];
        end
    endgenerate

    // Opcode acceptance and byte-write qualification
    always_comb begin
        cmd_ok  = (cmd_op == OP_READ) || (cmd_op == OP_WRITE);
        is_byte = 1'b0;
`ifdef SERIAL_MEM_BYTE_WRITE_EN
        cmd_ok  = cmd_ok || (cmd_op == OP_BYTE_WRITE);
        is_byte = (op_q == OP_BYTE_WRITE);
`endif
    end

    assign addr_d      = (addr_q >> IO_BITS) | (16'(tx_pins) << (WORD_BITS - IO_BITS));
    assign data_d      = (data_q >> IO_BITS) | (16'(tx_pins) << (WORD_BITS - IO_BITS));
    assign last_beat   = (beat_q == 5'(BEATS - 1));
    assign fetch_start = (state_q == IDLE) && (|tx_pins) && tx_fetch;
    assign commit      = (state_q == DATA) && (beat_q == 5'(BEATS));

    // With no delay the start marker follows the request directly
    assign resp_state_d = (RESP_DELAY == 0) ? RESP : WAIT;
    assign resp_rx_d    = (RESP_DELAY == 0) ? IO_BITS'(1) : '0;

    // Single write port: backdoor load takes priority over a serial commit
    always_comb begin
        ram_we    = commit;
        ram_be    = 2'b11;
        ram_waddr = addr_q[AW:1];
        ram_wdata = data_q;
        if (is_byte) begin
            ram_wdata = {data_q[7:0], data_q[7:0]};
            ram_be    = addr_q[0] ? 2'b10 : 2'b01;
        end
        if (ld_we) begin
            ram_we    = 1'b1;
            ram_be    = 2'b11;
            ram_waddr = ld_addr;
            ram_wdata = ld_data;
        end
    end

    assign ram_re    = fetch_start || ((state_q == ADDR) && last_beat && (op_q == OP_READ));
    assign ram_raddr = fetch_start ? pc_q[AW:1] : addr_d[AW:1];

    serial_mem_ram #(.AW(AW)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // Transaction sequencer: command, address/data shift-in, delay, serial response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            wait_q  <= '0;
            op_q    <= '0;
            jump_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            pc_q    <= '0;
            shift_q <= '0;
            rx_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    rx_q <= '0;
                    if (|tx_pins) begin
                        if (tx_fetch) begin
                            pc_q    <= pc_q + 16'd2;
                            state_q <= resp_state_d;
                            rx_q    <= resp_rx_d;
                            beat_q  <= '0;
                            wait_q  <= '0;
                        end else if (cmd_ok) begin
                            op_q    <= cmd_op;
                            jump_q  <= tx_jump;
                            beat_q  <= '0;
                            state_q <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    addr_q <= addr_d;
                    if (last_beat) begin
                        beat_q <= '0;
                        if (op_q == OP_READ) begin
                            if (jump_q) pc_q <= addr_d + 16'd2;
                            state_q <= resp_state_d;
                            rx_q    <= resp_rx_d;
                            wait_q  <= '0;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        beat_q <= beat_q + 5'd1;
                    end
                end
                DATA: begin
                    if (commit) begin
                        // A backdoor write to another word holds the port; retry next cycle
                        if (!(ld_we && (ld_addr != addr_q[AW:1]))) state_q <= IDLE;
                    end else begin
                        data_q <= data_d;
                        beat_q <= beat_q + 5'd1;
                    end
                end
                WAIT: begin
                    if (wait_q == 4'(RESP_DELAY - 1)) begin
                        state_q <= RESP;
                        rx_q    <= IO_BITS'(1);
                        beat_q  <= '0;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                RESP: begin
                    if (beat_q == 5'(BEATS)) begin
                        rx_q    <= '0;
                        state_q <= IDLE;
                    end else begin
                        if (beat_q == 5'd0) begin
                            rx_q    <= ram_rdata[IO_BITS-1:0];
                            shift_q <= ram_rdata >> IO_BITS;
                        end else begin
                            rx_q    <= shift_q[IO_BITS-1:0];
                            shift_q <= shift_q >> IO_BITS;
                        end
                        beat_q <= beat_q + 5'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_pins = rx_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: doc/serial_mem_responder.md
Name: serial_mem_responder

Overview:
- Memory-side end of the CPU's serial memory bus: decodes commands shifted out on tx_pins/tx_fetch/tx_jump, holds a word RAM and an instruction-fetch pointer, and returns read data serially on rx_pins.
- Sits off-chip-equivalent (testbench / FPGA companion) or on-chip for self-test, wired directly to the CPU bus pins.

Parameters:
- IO_BITS, 2, bus width per beat; must divide 16; BEATS = 16/IO_BITS.
- MEM_WORDS_LOG2, 8, RAM depth in 16-bit words; uses address bits [MEM_WORDS_LOG2:1], higher bits ignored (aliasing).
- RESP_DELAY, 1, idle cycles between end of request and response start marker; 0..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- tx_fetch  in  1  command-cycle flag: instruction fetch from internal PC, no address phase
- tx_jump  in  1  command-cycle flag on READ: load PC from the sent address
- tx_pins  in  IO_BITS  serial command/address/data from CPU
- rx_pins  out  IO_BITS  serial response to CPU, registered
- busy  out  1  high whenever state != IDLE
- ld_we  in  1  host backdoor word write
- ld_addr  in  MEM_WORDS_LOG2  backdoor word address
- ld_data  in  16  backdoor write data

Behaviour:
- Reset (async, rst_n low): state IDLE, rx_pins=0, busy=0, pc=0, counters 0. RAM contents not reset.
- IDLE: tx_pins=0 means no command. Non-zero tx_pins = command cycle (C); opcode = tx_pins[1:0]: 1 READ, 2 WRITE, 3 BYTE_WRITE (optional), else ignored, stay IDLE. tx_fetch/tx_jump sampled in C only.
- tx_fetch=1 in C (any non-zero opcode): FETCH; no address beats; word at pc read; pc <= pc+2 (16-bit wrap at 0xFFFE->0x0000).
- ADDR: BEATS cycles after C, LSB beat first, shift into 16-bit addr.
- READ: after last address beat, RAM read; if tx_jump was set, pc <= addr+2.
- WRITE: then DATA phase, BEATS cycles LSB first; word written in cycle after last data beat; no response; back to IDLE.
- WAIT: RESP_DELAY cycles with rx_pins=0.
- RESP: one start beat rx_pins=1, then BEATS data beats LSB first, then rx_pins=0, IDLE.
- Timing (C=cycle 0, IO_BITS=2, RESP_DELAY=1): READ start marker visible on rx_pins at cycle 10, data cycles 11..18; FETCH start marker at cycle 2, data 3..10; WRITE busy drops cycle 18.
- tx_pins/tx_fetch/tx_jump ignored outside IDLE and the beat being consumed; a command during RESP is dropped, not queued.
- Backdoor ld_we writes any cycle; same-cycle same-address collision with serial write: ld wins. Read-during-backdoor-write returns new data.
- Reset mid-operation: transaction aborted, rx_pins 0 immediately (async), no partial write committed.

Optional Feature:
- SERIAL_MEM_BYTE_WRITE_EN: defined -> opcode 3 is BYTE_WRITE: address + full BEATS data beats; only data[7:0] written to byte addr[0] (0 = low, 1 = high). Undefined -> opcode 3 ignored in IDLE like 0.

Decomposition:
- Package serial_mem_pkg: state enum (IDLE, ADDR, DATA, WAIT, RESP), opcode constants OP_READ=1, OP_WRITE=2, OP_BYTE_WRITE=3, WORD_BITS=16.
- Sub-module serial_mem_ram: synchronous word RAM, one write port muxed (backdoor/serial), byte enables, one read port.

Test Plan:
- Backdoor write 0x1234 @ word 0x10; READ addr 0x0020 -> rx start marker cycle 10, beats 0,1,3,0,2,0,1,0 (LSB first).
- WRITE addr 0x0040 data 0xBEEF, then READ 0x0040 -> returns 0xBEEF; busy low cycle 18.
- READ 0x0100 with tx_jump, then two FETCHes -> words at 0x0102, 0x0104; pc ends 0x0106.
- Byte write (macro on) 0xAA to byte addr 0x0041 over 0xBEEF -> read 0xAAEF; macro off -> no busy, word unchanged.
- Command on tx_pins during RESP -> ignored, response completes intact; rst_n low mid-ADDR -> rx_pins 0, busy 0, pc 0, RAM unchanged.
- MEM_WORDS_LOG2=8: WRITE 0x0202 aliases word 1 -> READ 0x0002 returns same data.
